// File: rtl/stage_database_writer_if.sv
// stage_database_writer_if: host-side word stream and RAM write port bundle of the stage database writer
//   master: host/testbench side, drives i_start/i_valid/i_data and observes every o_* signal
//   slave : writer side, consumes i_start/i_valid/i_data and drives every o_* signal
interface stage_database_writer_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH_12 = 12
);
  logic                     i_start;
  logic                     i_valid;
  logic [DATA_WIDTH_12-1:0] i_data;
  logic                     o_ready;
  logic                     o_wren;
  logic [ADDR_WIDTH-1:0]    o_wr_address;
  logic [DATA_WIDTH_12-1:0] o_wr_data;
  logic [ADDR_WIDTH-1:0]    o_tree_index;
  logic [ADDR_WIDTH-1:0]    o_classifier_index;
  logic                     o_end_count_classifier_index;
  logic                     o_end_count_database_index;
  logic                     o_busy;
  logic                     o_done;
  logic [15:0]              o_checksum;
  modport master (
    output i_start, i_valid, i_data,
    input  o_ready, o_wren, o_wr_address, o_wr_data, o_tree_index, o_classifier_index,
           o_end_count_classifier_index, o_end_count_database_index, o_busy, o_done, o_checksum
  );
  modport slave (
    input  i_start, i_valid, i_data,
    output o_ready, o_wren, o_wr_address, o_wr_data, o_tree_index, o_classifier_index,
           o_end_count_classifier_index, o_end_count_database_index, o_busy, o_done, o_checksum
  );
endinterface

// File: rtl/stage_database_writer.sv
// stage_database_writer: loads one Haar cascade stage (tree parameters then stage thresholds) into the stage database RAM
//   clk_fpga, reset_fpga        : single clock, synchronous active-high reset
//   bus.i_start/i_valid/i_data  : load request and 12-bit word stream, accepted when i_valid && o_ready
//   bus.o_wren/o_wr_address/o_wr_data : RAM write port, one write the cycle after each accepted word
//   bus.o_tree_index/o_classifier_index/o_end_count_* : position of the word being written
//   bus.o_busy/o_done/o_checksum : load status and running word checksum
//   Optional: define STAGE_DATABASE_WRITER_CHECKSUM_EN to build the checksum adder; otherwise o_checksum is 0
module stage_database_writer #(
  parameter int ADDR_WIDTH               = 10,
  parameter int DATA_WIDTH_12            = 12,
  parameter int NUM_CLASSIFIERS_STAGE    = 10,
  parameter int NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int NUM_STAGE_THRESHOLD      = 3
) (
  input logic                    clk_fpga,
  input logic                    reset_fpga,
  stage_database_writer_if.slave bus
);
  localparam int TOTAL = NUM_CLASSIFIERS_STAGE * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
  localparam logic [ADDR_WIDTH-1:0] LAST_PARAM  = ADDR_WIDTH'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_TREE   = ADDR_WIDTH'(NUM_CLASSIFIERS_STAGE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_THRESH = ADDR_WIDTH'(NUM_STAGE_THRESHOLD - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(TOTAL - 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD_TREE, S_LOAD_THRESH, S_DONE} state_t;
  state_t                   r_state;
  logic                     r_ready;
  logic                     r_wren;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_end_cls;
  logic                     r_end_db;
  logic [ADDR_WIDTH-1:0]    r_cnt;
  logic [ADDR_WIDTH-1:0]    r_tree;
  logic [ADDR_WIDTH-1:0]    r_cls;
  logic [ADDR_WIDTH-1:0]    r_wr_address;
  logic [ADDR_WIDTH-1:0]    r_tree_index;
  logic [ADDR_WIDTH-1:0]    r_classifier_index;
  logic [DATA_WIDTH_12-1:0] r_wr_data;
  logic                     w_accept;
  logic                     w_start;
  assign w_accept = bus.i_valid && r_ready;
  assign w_start  = bus.i_start && (r_state == S_IDLE || r_state == S_DONE);
  // r_cls doubles as the threshold index; r_tree reaches NUM_CLASSIFIERS_STAGE while thresholds load
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      r_state            <= S_IDLE;
      r_ready            <= 1'b0;
      r_wren             <= 1'b0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_end_cls          <= 1'b0;
      r_end_db           <= 1'b0;
      r_cnt              <= '0;
      r_tree             <= '0;
      r_cls              <= '0;
      r_wr_address       <= '0;
      r_tree_index       <= '0;
      r_classifier_index <= '0;
      r_wr_data          <= '0;
    end else begin
      r_wren    <= w_accept;
      r_end_cls <= w_accept && r_state == S_LOAD_TREE && r_cls == LAST_PARAM;
      r_end_db  <= w_accept && r_cnt == LAST_ADDR;
      if (w_accept) begin
        r_wr_address       <= r_cnt;
        r_wr_data          <= bus.i_data;
        r_tree_index       <= r_tree;
        r_classifier_index <= r_cls;
        r_cnt              <= r_cnt + 1'b1;
      end
      if (w_start) begin
        r_state <= S_LOAD_TREE;
        r_ready <= 1'b1;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_cnt   <= '0;
        r_tree  <= '0;
        r_cls   <= '0;
      end else if (w_accept && r_state == S_LOAD_TREE) begin
        if (r_cls == LAST_PARAM) begin
          r_cls  <= '0;
          r_tree <= r_tree + 1'b1;
          if (r_tree == LAST_TREE) r_state <= S_LOAD_THRESH;
        end else begin
          r_cls <= r_cls + 1'b1;
        end
      end else if (w_accept && r_state == S_LOAD_THRESH) begin
        if (r_cls == LAST_THRESH) begin
          r_state <= S_DONE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_cls <= r_cls + 1'b1;
        end
      end
    end
  end
  assign bus.o_ready                      = r_ready;
  assign bus.o_wren                       = r_wren;
  assign bus.o_wr_address                 = r_wr_address;
  assign bus.o_wr_data                    = r_wr_data;
  assign bus.o_tree_index                 = r_tree_index;
  assign bus.o_classifier_index           = r_classifier_index;
  assign bus.o_end_count_classifier_index = r_end_cls;
  assign bus.o_end_count_database_index   = r_end_db;
  assign bus.o_busy                       = r_busy;
  assign bus.o_done                       = r_done;
`ifdef STAGE_DATABASE_WRITER_CHECKSUM_EN
  logic [15:0] r_checksum;
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga || w_start) r_checksum <= '0;
    else if (w_accept) r_checksum <= r_checksum + 16'(bus.i_data);
  end
  assign bus.o_checksum = r_checksum;
`else
  assign bus.o_checksum = '0;
`endif
endmodule

// File: tb/tb_stage_database_writer.sv
// tb_stage_database_writer: directed self-checking bench for stage_database_writer
module tb_stage_database_writer;
  localparam int NC = 10;
  localparam int NP = 19;
  localparam int NT = 3;
  localparam int TREE_WORDS = NC * NP;
  localparam int TOTAL = TREE_WORDS + NT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int n_ecls = 0;
  stage_database_writer_if bus ();
  stage_database_writer dut (.clk_fpga(clk), .reset_fpga(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic write_word(input int k, input logic [11:0] d);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    step();
    chk($sformatf("wren[%0d]", k), 32'(bus.o_wren), 32'd1);
    chk($sformatf("addr[%0d]", k), 32'(bus.o_wr_address), 32'(k));
    chk($sformatf("data[%0d]", k), 32'(bus.o_wr_data), 32'(d));
    chk($sformatf("tree[%0d]", k), 32'(bus.o_tree_index), 32'(k < TREE_WORDS ? k / NP : NC));
    chk($sformatf("cls[%0d]", k), 32'(bus.o_classifier_index), 32'(k < TREE_WORDS ? k % NP : k - TREE_WORDS));
    chk($sformatf("ecls[%0d]", k), 32'(bus.o_end_count_classifier_index), 32'(k < TREE_WORDS && k % NP == NP - 1));
    chk($sformatf("edb[%0d]", k), 32'(bus.o_end_count_database_index), 32'(k == TOTAL - 1));
    chk($sformatf("done[%0d]", k), 32'(bus.o_done), 32'(k == TOTAL - 1));
    chk($sformatf("busy[%0d]", k), 32'(bus.o_busy), 32'(k != TOTAL - 1));
    if (bus.o_end_count_classifier_index) n_ecls++;
  endtask
  task automatic start_load();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk("start_ready", 32'(bus.o_ready), 32'd1);
    chk("start_busy", 32'(bus.o_busy), 32'd1);
    chk("start_done", 32'(bus.o_done), 32'd0);
    chk("start_wren", 32'(bus.o_wren), 32'd0);
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    step();
    step();
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_wren", 32'(bus.o_wren), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_addr", 32'(bus.o_wr_address), 32'd0);
    chk("rst_data", 32'(bus.o_wr_data), 32'd0);
    chk("rst_tree", 32'(bus.o_tree_index), 32'd0);
    chk("rst_cls", 32'(bus.o_classifier_index), 32'd0);
    chk("rst_ecls", 32'(bus.o_end_count_classifier_index), 32'd0);
    chk("rst_edb", 32'(bus.o_end_count_database_index), 32'd0);
    chk("rst_csum", 32'(bus.o_checksum), 32'd0);
    rst = 1'b0;
    bus.i_valid = 1'b1;
    step();
    chk("idle_valid_wren", 32'(bus.o_wren), 32'd0);
    bus.i_valid = 1'b0;
    start_load();
    for (int k = 0; k < TOTAL; k++) write_word(k, 12'(k));
    chk("ecls_pulses", 32'(n_ecls), 32'd10);
`ifdef STAGE_DATABASE_WRITER_CHECKSUM_EN
    chk("csum_ramp", 32'(bus.o_checksum), 32'h4860);
`else
    chk("csum_ramp", 32'(bus.o_checksum), 32'd0);
`endif
    step();
    chk("after_done_wren", 32'(bus.o_wren), 32'd0);
    chk("after_done_ready", 32'(bus.o_ready), 32'd0);
    chk("after_done_done", 32'(bus.o_done), 32'd1);
    chk("after_done_busy", 32'(bus.o_busy), 32'd0);
    chk("after_done_addr", 32'(bus.o_wr_address), 32'd192);
    chk("after_done_edb", 32'(bus.o_end_count_database_index), 32'd0);
    bus.i_valid = 1'b0;
    start_load();
    for (int k = 0; k < TOTAL; k++) begin
      write_word(k, 12'(k * 37 + 5));
      bus.i_valid = 1'b0;
      step();
      chk($sformatf("gap_wren[%0d]", k), 32'(bus.o_wren), 32'd0);
      chk($sformatf("gap_addr[%0d]", k), 32'(bus.o_wr_address), 32'(k));
    end
    chk("gap_done", 32'(bus.o_done), 32'd1);
    start_load();
    for (int k = 0; k < 50; k++) write_word(k, 12'(k ^ 12'hA5A));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_wren", 32'(bus.o_wren), 32'd0);
    chk("midrst_busy", 32'(bus.o_busy), 32'd0);
    chk("midrst_ready", 32'(bus.o_ready), 32'd0);
    chk("midrst_addr", 32'(bus.o_wr_address), 32'd0);
    step();
    chk("midrst_idle_wren", 32'(bus.o_wren), 32'd0);
    bus.i_valid = 1'b0;
    start_load();
    for (int k = 0; k < TOTAL; k++) begin
      bus.i_start = (k == 100);
      write_word(k, 12'(k * 37 + 5));
      bus.i_start = 1'b0;
    end
    step();
    chk("extra_valid_wren", 32'(bus.o_wren), 32'd0);
    chk("extra_valid_done", 32'(bus.o_done), 32'd1);
    bus.i_valid = 1'b0;
    start_load();
    chk("restart_csum", 32'(bus.o_checksum), 32'd0);
    for (int k = 0; k < TOTAL; k++) write_word(k, 12'hFFF);
`ifdef STAGE_DATABASE_WRITER_CHECKSUM_EN
    chk("csum_fff", 32'(bus.o_checksum), 32'h0F3F);
`else
    chk("csum_fff", 32'(bus.o_checksum), 32'd0);
`endif
    bus.i_valid = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
